// File: rtl/fairy_muldiv_pkg.sv
// fairy_muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op_i encodings issued by the execute stage
//   - FSM state type used by fairy_muldiv_unit
package fairy_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_t;

endpackage

// File: rtl/fairy_muldiv_step.sv
// fairy_muldiv_step: one combinational iteration of the mul/div datapath.
//   i_mode_div : 0 = shift-add multiply step, 1 = restoring divide step
//   i_hi/i_lo  : current accumulator pair
//                MUL: partial product high half / multiplier bits still to consume
//                DIV: partial remainder / dividend bits being shifted into quotient
//   i_opnd     : multiplicand magnitude (MUL) or divisor magnitude (DIV)
//   o_hi/o_lo  : accumulator pair after this iteration
module fairy_muldiv_step #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic            i_mode_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN+MUL_BITS-1:0] w_a_ext;
  logic [XLEN+MUL_BITS-1:0] w_m_ext;
  logic [XLEN+MUL_BITS-1:0] w_pp;
  logic [XLEN+MUL_BITS-1:0] w_sum;
  logic [XLEN:0]            w_shift;
  logic                     w_ge;

  // hi + multiplicand * (low MUL_BITS of multiplier) always fits XLEN+MUL_BITS bits
  assign w_a_ext = {{MUL_BITS{1'b0}}, i_opnd};
  assign w_m_ext = {{XLEN{1'b0}}, i_lo[MUL_BITS-1:0]};
  assign w_pp    = w_a_ext * w_m_ext;
  assign w_sum   = {{MUL_BITS{1'b0}}, i_hi} + w_pp;

  assign w_shift = {i_hi, i_lo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_opnd});

  always_comb begin
    // {sum, multiplier} shifted right by MUL_BITS; consumed multiplier bits drop out
    o_hi = w_sum[XLEN+MUL_BITS-1:MUL_BITS];
    o_lo = {w_sum[MUL_BITS-1:0], i_lo[XLEN-1:MUL_BITS]};
    if (i_mode_div) begin
      // difference is below the divisor, so the top bit of w_shift can be dropped
      o_hi = w_ge ? (w_shift[XLEN-1:0] - i_opnd) : w_shift[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_ge};
    end
  end

endmodule

// File: rtl/fairy_muldiv_unit.sv
// fairy_muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//   clk, reset       : clock, asynchronous active-high reset
//   start_i, op_i    : issue request and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a_i, b_i         : rs / rt operands
//   flush_i          : cancels any in-flight operation, blocks issue this cycle
//   busy_o           : iteration in progress
//   done_o           : one-cycle pulse after HI/LO written by MUL/DIV
//   hi_o, lo_o       : HI / LO registers
module fairy_muldiv_unit
  import fairy_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int unsigned MUL_ITERS = XLEN / MUL_BITS;
  localparam int unsigned CW        = $clog2(XLEN);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_acc_hi, r_acc_lo, r_opnd, r_a_raw;
  logic [XLEN-1:0]   r_hi, r_lo;
  logic              r_neg_q, r_neg_r, r_is_div, r_div_zero, r_done;

  logic              w_issue, w_md_op, w_div_op, w_signed_op, w_accept;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN-1:0]   w_step_hi, w_step_lo;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]   w_res_hi, w_res_lo;

  assign w_issue     = (r_state == ST_IDLE) && start_i && !flush_i;
  assign w_div_op    = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign w_md_op     = (op_i == OP_MULT) || (op_i == OP_MULTU) || w_div_op;
  assign w_signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign w_accept    = w_issue && w_md_op;

  assign w_a_neg = w_signed_op && a_i[XLEN-1];
  assign w_b_neg = w_signed_op && b_i[XLEN-1];
  assign w_a_mag = w_a_neg ? -a_i : a_i;
  assign w_b_mag = w_b_neg ? -b_i : b_i;

  fairy_muldiv_step #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_step (
    .i_mode_div (r_is_div),
    .i_hi       (r_acc_hi),
    .i_lo       (r_acc_lo),
    .i_opnd     (r_opnd),
    .o_hi       (w_step_hi),
    .o_lo       (w_step_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_div_op ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV: begin
        if (flush_i)              w_state_nxt = ST_IDLE;
        else if (r_cnt == '0)     w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Iteration datapath: MUL keeps {partial high, multiplier} and shifts right;
  // DIV keeps {remainder, dividend/quotient} and shifts left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opnd     <= '0;
      r_a_raw    <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_is_div   <= 1'b0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= w_div_op ? CW'(XLEN - 1) : CW'(MUL_ITERS - 1);
      r_acc_hi   <= '0;
      r_acc_lo   <= w_div_op ? w_a_mag : w_b_mag;
      r_opnd     <= w_div_op ? w_b_mag : w_a_mag;
      r_a_raw    <= a_i;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_is_div   <= w_div_op;
      r_div_zero <= (b_i == '0);
    end else if (r_state == ST_MUL || r_state == ST_DIV) begin
      r_cnt    <= r_cnt - 1'b1;
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
    end
  end

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  always_comb begin
    w_res_hi = w_prod_fix[2*XLEN-1:XLEN];
    w_res_lo = w_prod_fix[XLEN-1:0];
    if (r_is_div) begin
      if (r_div_zero) begin
        w_res_hi = r_a_raw;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
        w_res_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_FIX && !flush_i) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end else if (w_issue) begin
        if (op_i == OP_MTHI) r_hi <= a_i;
        if (op_i == OP_MTLO) r_lo <= a_i;
      end
    end
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_fairy_muldiv_unit.sv
module tb_fairy_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hi, m_lo;

  fairy_muldiv_unit #(.XLEN(32), .MUL_BITS(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural reference: HI/LO after an op, from plain integer arithmetic.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint     sp;
    logic [63:0] up;
    int         sx, sy;
    case (o)
      3'd0: begin sp = longint'($signed(x)) * longint'($signed(y)); {m_hi, m_lo} = sp; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = up; end
      3'd2: begin
        if (y == 0) begin m_lo = 32'hFFFFFFFF; m_hi = x; end
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin m_lo = x; m_hi = 0; end
        else begin sx = x; sy = y; m_lo = sx / sy; m_hi = sx % sy; end
      end
      3'd3: begin
        if (y == 0) begin m_lo = 32'hFFFFFFFF; m_hi = x; end
        else begin m_lo = x / y; m_hi = x % y; end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    model_op(o, x, y);
    if (o <= 3'd3) begin
      check($sformatf("op%0d_busy", o), busy, 1);
      lat = 0;
      while (!done && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("op%0d_latency", o), lat, (o >= 3'd2) ? 33 : 9);
      check($sformatf("op%0d_busy_end", o), busy, 0);
    end else begin
      check($sformatf("op%0d_busy", o), busy, 0);
      check($sformatf("op%0d_done", o), done, 0);
    end
    check($sformatf("op%0d_hi a=%h b=%h", o, x, y), hi, m_hi);
    check($sformatf("op%0d_lo a=%h b=%h", o, x, y), lo, m_lo);
  endtask

  initial begin
    int lat;
    logic seen;
    int r;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // directed values
    run_op(3'd0, 32'd7, 32'hFFFFFFFD);
    run_op(3'd1, 32'd7, 32'hFFFFFFFD);
    run_op(3'd3, 32'd100, 32'd7);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd3, 32'h1234, 32'd0);
    run_op(3'd2, 32'hFFFFFF00, 32'd0);
    run_op(3'd4, 32'hDEADBEEF, 32'd0);
    run_op(3'd5, 32'h5, 32'd0);

    // flush mid-DIVU, then a normal MULT
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("flush_busy", busy, 0);
    seen = done;
    repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
    check("flush_nodone", seen, 0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    run_op(3'd0, 32'd12345, 32'hFFFF0000);

    // flush during the final (fix-up) cycle of a MULTU
    start = 1'b1; op = 3'd1; a = 32'h11111111; b = 32'h22222222;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    check("fixflush_busy_pre", busy, 1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("fixflush_done", done, 0);
    check("fixflush_busy", busy, 0);
    check("fixflush_hi", hi, m_hi);
    check("fixflush_lo", lo, m_lo);

    // issue attempts while DIV busy are ignored
    start = 1'b1; op = 3'd2; a = 32'hFFFF8000; b = 32'd77;
    @(negedge clk); start = 1'b0;
    model_op(3'd2, 32'hFFFF8000, 32'd77);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk); op = 3'd4; a = 32'hAAAA5555;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("busyign_done", done, 1);
    check("busyign_hi", hi, m_hi);
    check("busyign_lo", lo, m_lo);

    // flush and start together: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h12121212;
    @(negedge clk);
    check("flushstart_mthi", hi, m_hi);
    op = 3'd0;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("flushstart_busy", busy, 0);

    // randomized mix, including divide-by-zero and signed overflow corners
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom; rb = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) rb = 32'd0;
      else if (r == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (r == 2) rb = 32'($urandom_range(1, 15));
      run_op(ro, ra, rb);
    end

    // asynchronous reset mid-MUL
    @(negedge clk);
    run_op(3'd4, 32'hCAFEF00D, 32'd0);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_op(3'd1, 32'd3, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fairy_muldiv_unit.md
Name: fairy_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the execute stage.
- Execute stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO and reads HI/LO for MFHI/MFLO.
- Parametrised in datapath width and multiplier bits-per-cycle.
- Supports exception flush mid-operation, which the single-cycle execute path cannot.

Parameters:
XLEN, 32, operand and HI/LO width (even, >=8)
MUL_BITS, 4, multiplier bits retired per cycle; must divide XLEN (1, 2, 4, 8)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start_i  input  1  issue request, sampled on rising edge
op_i  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; others = no-op
a_i  input  XLEN  rs operand
b_i  input  XLEN  rt operand
flush_i  input  1  exception flush; cancels in-flight op
busy_o  output  1  iteration in progress; execute stage stalls MF*/MT*/MUL/DIV
done_o  output  1  one-cycle pulse: HI/LO just updated by MUL/DIV
hi_o  output  XLEN  HI register
lo_o  output  XLEN  LO register

Behaviour:
- Reset (asynchronous, active-high):
  - hi_o=0, lo_o=0, busy_o=0, done_o=0.
  - State=IDLE; internal accumulators cleared.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start_i & ~flush_i & op in {0..3}: latch operands, take magnitudes for signed ops, record result signs, go to MUL or DIV; busy_o=1 from next cycle.
  - start_i & op=4/5: HI or LO <= a_i at that edge; no busy, no done.
- MUL:
  - Shift-add; each cycle consumes MUL_BITS multiplier bits.
  - Runs XLEN/MUL_BITS cycles, then FIX.
  - Product width 2*XLEN.
- DIV:
  - Restoring, 1 quotient bit per cycle.
  - Runs XLEN cycles, then FIX.
- FIX:
  - Apply sign correction, write {HI,LO}, pulse done_o, busy_o=0 at the same edge, return to IDLE.
  - MUL: HI = product upper half, LO = product lower half.
  - DIV: LO = quotient, HI = remainder.
  - Signed DIV: quotient negative iff operand signs differ; remainder takes dividend sign.
- Latency from accept edge to HI/LO update:
  - MUL: XLEN/MUL_BITS+1 cycles (9 at defaults).
  - DIV: XLEN+1 cycles (33).
- Divide by zero: LO = all ones, HI = dividend (raw a_i); same latency.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0; falls out of magnitude arithmetic, no special case.
- start_i while busy_o=1: ignored (execute stage must hold it). This includes MTHI/MTLO.
- flush_i while busy_o=1 (including FIX cycle): abort, HI/LO unchanged, no done_o, IDLE next cycle.
- flush_i and start_i in the same cycle: flush wins; nothing accepted.
- Back-to-back: a new start_i may be accepted in the cycle done_o is high.
- hi_o/lo_o are registered; only FIX or MTHI/MTLO modify them.

Decomposition:
- Shared package fairy_muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO)
  - state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX)
- One sub-module, fairy_muldiv_step:
  - combinational single iteration
  - MUL mode: MUL_BITS partial-product add and shift
  - DIV mode: trial subtract/restore
  - Keeps the top module to control plus sign fix.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done_o 9 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIVU a=100, b=7 -> done_o after 33 cycles; LO=14, HI=2. DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234.
- MTHI a=0xDEADBEEF, then MTLO a=0x5 in consecutive cycles -> hi_o/lo_o update next edge; busy_o and done_o stay 0.
- DIVU started, flush_i at cycle 10 -> busy_o=0 next cycle, done_o never pulses, HI/LO keep prior values. New MULT issued next cycle -> completes normally.
- MULT issued while DIV is busy -> ignored, DIV result correct. Assert reset mid-MUL -> all outputs 0 immediately (asynchronous).
